// File: rtl/sysex_patch_dump_if.sv
// Register-bus and MIDI-transmit bundle for the SysEx patch dumper.
// master = the dumper, slave = register files + transmitter + control.
interface sysex_patch_dump_if #(
    parameter int N_SECT = 4
);
    logic              dump_start;
    logic              dump_abort;
    logic              dump_busy;
    logic              dump_done;
    logic [N_SECT-1:0] sect_sel;
    logic [6:0]        adr;
    logic              read;
    logic              sysex_data_patch_send;
    logic [7:0]        data_in;
    logic [7:0]        tx_byte;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        input  dump_start, dump_abort, data_in, tx_ready,
        output dump_busy, dump_done, sect_sel, adr, read,
        output sysex_data_patch_send, tx_byte, tx_valid
    );

    modport slave (
        output dump_start, dump_abort, data_in, tx_ready,
        input  dump_busy, dump_done, sect_sel, adr, read,
        input  sysex_data_patch_send, tx_byte, tx_valid
    );
endinterface

// File: rtl/sysex_patch_dump.sv
// Walks every section/address of the parameter register bus and streams
// the captured patch out as a nibblised MIDI SysEx message.
module sysex_patch_dump #(
    parameter int         N_SECT   = 4,
    parameter int         ADR_LAST = 127,
    parameter logic [7:0] MFR_ID   = 8'h7D,
    parameter logic [7:0] DEV_ID   = 8'h01
) (
    input logic                sCLK_XVXOSC,
    input logic                reset_reg_N,
    sysex_patch_dump_if.master bus
);
    localparam int SW = (N_SECT > 1) ? $clog2(N_SECT) : 1;
    localparam logic [SW-1:0] SECT_LAST = SW'(N_SECT - 1);
    localparam logic [6:0]    ADR_MAX   = 7'(ADR_LAST);

    typedef enum logic [3:0] {
        S_IDLE, S_H0, S_H1, S_H2, S_H3,
        S_SETUP, S_RD, S_WAIT, S_CAP,
        S_SHI, S_SLO, S_CK, S_EOX, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] sect_q, sect_d;
    logic [6:0]    adr_q, adr_d;
    logic [7:0]    data_q, data_d;
    logic [6:0]    sum_q, sum_d;
    logic          abort_q, abort_d;

    logic       emit;
    logic       xfer;
    logic       on_bus;
    logic [7:0] byte_out;
    logic [6:0] ck_byte;

    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q <= S_IDLE;
            sect_q  <= '0;
            adr_q   <= '0;
            data_q  <= '0;
            sum_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sect_q  <= sect_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
            abort_q <= abort_d;
        end
    end

    assign ck_byte = 7'd0 - sum_q;

    always_comb begin
        emit     = 1'b0;
        byte_out = 8'h00;
        unique case (state_q)
            S_H0:  begin emit = 1'b1; byte_out = 8'hF0;              end
            S_H1:  begin emit = 1'b1; byte_out = MFR_ID;             end
            S_H2:  begin emit = 1'b1; byte_out = DEV_ID;             end
            S_H3:  begin emit = 1'b1; byte_out = 8'(sect_q);         end
            S_SHI: begin emit = 1'b1; byte_out = {4'h0, data_q[7:4]}; end
            S_SLO: begin emit = 1'b1; byte_out = {4'h0, data_q[3:0]}; end
            S_CK:  begin emit = 1'b1; byte_out = {1'b0, ck_byte};    end
            S_EOX: begin emit = 1'b1; byte_out = 8'hF7;              end
            default: ;
        endcase
    end

    assign xfer = emit & bus.tx_ready;

    always_comb begin
        state_d = state_q;
        sect_d  = sect_q;
        adr_d   = adr_q;
        data_d  = data_q;
        sum_d   = sum_q;
        abort_d = abort_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.dump_start) begin
                    state_d = S_H0;
                    sect_d  = '0;
                    adr_d   = '0;
                    sum_d   = '0;
                    abort_d = 1'b0;
                end
            end
            S_H0:    if (xfer) state_d = S_H1;
            S_H1:    if (xfer) state_d = S_H2;
            S_H2:    if (xfer) state_d = S_H3;
            S_H3:    if (xfer) state_d = S_SETUP;
            S_SETUP: state_d = S_RD;
            S_RD:    state_d = S_WAIT;
            S_WAIT:  state_d = S_CAP;
            S_CAP: begin
                data_d  = bus.data_in;
                state_d = S_SHI;
            end
            S_SHI: begin
                if (xfer) begin
                    sum_d   = sum_q + 7'(data_q[7:4]);
                    state_d = S_SLO;
                end
            end
            S_SLO: begin
                if (xfer) begin
                    sum_d = sum_q + 7'(data_q[3:0]);
                    if (adr_q < ADR_MAX) begin
                        adr_d   = adr_q + 7'd1;
                        state_d = S_SETUP;
                    end else if (sect_q != SECT_LAST) begin
                        sect_d  = sect_q + SW'(1);
                        adr_d   = '0;
                        state_d = S_H3;
                    end else begin
                        state_d = S_CK;
                    end
                end
            end
            S_CK:  if (xfer) state_d = S_EOX;
            S_EOX: if (xfer) state_d = S_DONE;
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A pending emit finishes its handshake before the early F7.
        if (state_q != S_IDLE && state_q != S_EOX && state_q != S_DONE) begin
            if (emit) begin
                if (bus.dump_abort || abort_q) begin
                    if (xfer) state_d = S_EOX;
                    else      abort_d = 1'b1;
                end
            end else if (bus.dump_abort) begin
                state_d = S_EOX;
            end
        end
    end

    assign on_bus = (state_q == S_SETUP) || (state_q == S_RD) ||
                    (state_q == S_WAIT)  || (state_q == S_CAP);

    assign bus.dump_busy             = (state_q != S_IDLE);
    assign bus.dump_done             = (state_q == S_DONE);
    assign bus.read                  = (state_q == S_RD);
    assign bus.sysex_data_patch_send = on_bus;
    assign bus.sect_sel = on_bus ? (N_SECT'(1) << sect_q) : '0;
    assign bus.adr      = on_bus ? adr_q : 7'd0;
    assign bus.tx_valid = emit;
    assign bus.tx_byte  = byte_out;
endmodule

// File: tb/tb_sysex_patch_dump.sv
// Randomised bench for sysex_patch_dump: responder, stalling transmitter
// and a stream-level reference model of the expected SysEx message.
module tb_sysex_patch_dump;
    localparam int NS = 4;
    localparam int AL = 127;
    localparam int BOUND = 30000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sysex_patch_dump_if #(.N_SECT(NS)) dut_if ();

    sysex_patch_dump #(
        .N_SECT(NS), .ADR_LAST(AL), .MFR_ID(8'h7D), .DEV_ID(8'h01)
    ) dut (
        .sCLK_XVXOSC(clk),
        .reset_reg_N(rst_n),
        .bus(dut_if.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] mem [NS][AL+1];
    logic [7:0] rsp_q = 8'h00;
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];

    // Responder: selected section latches its register on the read edge.
    always @(posedge dut_if.read) begin
        for (int s = 0; s < NS; s++)
            if (dut_if.sect_sel[s]) rsp_q = mem[s][dut_if.adr];
    end
    assign dut_if.data_in = dut_if.sysex_data_patch_send ? rsp_q : 8'hEE;

    int  mode = 0;
    bit  man_ready = 1'b1;
    bit  xfer_seen = 1'b0;
    int  stall = 0;

    always @(posedge clk) begin
        #1;
        case (mode)
            0: dut_if.tx_ready = 1'b1;
            1: begin
                if (xfer_seen) stall = $urandom_range(0, 5);
                if (stall > 0) begin
                    dut_if.tx_ready = 1'b0;
                    stall--;
                end else begin
                    dut_if.tx_ready = 1'b1;
                end
            end
            default: dut_if.tx_ready = man_ready;
        endcase
    end

    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    bit         prev_read = 1'b0;
    logic [6:0] prev_adr = 7'd0;
    int         n_reads = 0;
    int         n_done = 0;

    always @(negedge clk) begin
        if (prev_stall && dut_if.tx_valid)
            check("tx_hold", dut_if.tx_byte, prev_byte);
        xfer_seen = dut_if.tx_valid && dut_if.tx_ready;
        if (xfer_seen) rx.push_back(dut_if.tx_byte);
        prev_stall = dut_if.tx_valid && !dut_if.tx_ready;
        prev_byte = dut_if.tx_byte;
        if (dut_if.read) begin
            check("read_width", 32'(prev_read), 0);
            check("read_send", 32'(dut_if.sysex_data_patch_send), 1);
            check("read_adr", 32'(dut_if.adr), 32'(prev_adr));
            check("read_sel", 32'($onehot(dut_if.sect_sel)), 1);
            if (!prev_read) n_reads++;
        end
        if (dut_if.dump_done) n_done++;
        prev_read = dut_if.read;
        prev_adr = dut_if.adr;
    end

    task automatic fill_mem();
        for (int s = 0; s < NS; s++)
            for (int a = 0; a <= AL; a++)
                mem[s][a] = 8'($urandom);
    endtask

    task automatic build_exp();
        int sum;
        sum = 0;
        exp_q.delete();
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h7D);
        exp_q.push_back(8'h01);
        for (int s = 0; s < NS; s++) begin
            exp_q.push_back(8'(s));
            for (int a = 0; a <= AL; a++) begin
                exp_q.push_back(8'(mem[s][a] / 16));
                exp_q.push_back(8'(mem[s][a] % 16));
                sum += mem[s][a] / 16 + mem[s][a] % 16;
            end
        end
        exp_q.push_back(8'((128 - sum % 128) % 128));
        exp_q.push_back(8'hF7);
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            if (rx[i] !== exp_q[i]) begin
                $display("  first divergence at byte %0d", i);
                check({tag, "_byte"}, rx[i], exp_q[i]);
                break;
            end
        end
    endtask

    task automatic start_dump(input bit with_abort);
        @(negedge clk);
        rx.delete();
        n_reads = 0;
        n_done = 0;
        dut_if.dump_start = 1'b1;
        dut_if.dump_abort = with_abort;
        @(negedge clk);
        dut_if.dump_start = 1'b0;
        dut_if.dump_abort = 1'b0;
        check("busy_rise", dut_if.dump_busy, 1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!dut_if.dump_done && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", dut_if.dump_done, 1);
        @(negedge clk);
        @(negedge clk);
        check("busy_after", dut_if.dump_busy, 0);
        check("done_pulses", n_done, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, dut_if.dump_busy, 0);
        check({tag, "_done"}, dut_if.dump_done, 0);
        check({tag, "_sel"}, dut_if.sect_sel, 0);
        check({tag, "_adr"}, dut_if.adr, 0);
        check({tag, "_read"}, dut_if.read, 0);
        check({tag, "_send"}, dut_if.sysex_data_patch_send, 0);
        check({tag, "_txv"}, dut_if.tx_valid, 0);
        check({tag, "_txb"}, dut_if.tx_byte, 0);
    endtask

    initial begin
        int  k;
        bit  pr;
        dut_if.dump_start = 1'b0;
        dut_if.dump_abort = 1'b0;
        dut_if.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Abort while idle must do nothing.
        rx.delete();
        dut_if.dump_abort = 1'b1;
        @(negedge clk);
        dut_if.dump_abort = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_abort_busy", dut_if.dump_busy, 0);
        check("idle_abort_tx", rx.size(), 0);

        // Unstalled dump with known spot values; restart mid-dump ignored.
        mode = 0;
        fill_mem();
        mem[0][0] = 8'hA5;
        mem[0][6] = 8'hF3;
        mem[0][22] = 8'h10;
        build_exp();
        start_dump(1'b0);
        repeat (200) @(negedge clk);
        dut_if.dump_start = 1'b1;
        @(negedge clk);
        dut_if.dump_start = 1'b0;
        wait_done();
        cmp_stream("plain");
        check("plain_a0_hi", rx[4], 8'h0A);
        check("plain_a0_lo", rx[5], 8'h05);
        check("plain_a6_hi", rx[16], 8'h0F);
        check("plain_a6_lo", rx[17], 8'h03);
        check("plain_a22_hi", rx[48], 8'h01);
        check("plain_a22_lo", rx[49], 8'h00);
        check("plain_sect1", rx[4 + 2 * (AL + 1)], 8'h01);
        check("plain_reads", n_reads, NS * (AL + 1));

        // Stalled transmitter; start with simultaneous abort, start wins.
        mode = 1;
        fill_mem();
        build_exp();
        start_dump(1'b1);
        wait_done();
        cmp_stream("stall");
        check("stall_reads", n_reads, NS * (AL + 1));

        // Abort during the third address's high nibble while stalled.
        mode = 2;
        man_ready = 1'b1;
        fill_mem();
        build_exp();
        start_dump(1'b0);
        k = 0;
        while (rx.size() < 8 && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        man_ready = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!dut_if.tx_valid && k < BOUND);
        check("abort_at_shi", dut_if.tx_byte, exp_q[8]);
        dut_if.dump_abort = 1'b1;
        @(negedge clk);
        dut_if.dump_abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_held", rx.size(), 8);
        man_ready = 1'b1;
        wait_done();
        while (exp_q.size() > 9) void'(exp_q.pop_back());
        exp_q.push_back(8'hF7);
        cmp_stream("abort");
        check("abort_reads", n_reads, 3);

        // Reset dropped during WAIT, then a full fresh dump.
        mode = 1;
        fill_mem();
        build_exp();
        start_dump(1'b0);
        pr = 1'b0;
        k = 0;
        while (k < BOUND) begin
            @(negedge clk);
            k++;
            if (pr && !dut_if.read && dut_if.sysex_data_patch_send) break;
            pr = dut_if.read;
        end
        check("found_wait", k < BOUND, 1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        n_done = 0;
        repeat (3) @(negedge clk);
        check("midreset_nodone", n_done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_dump(1'b0);
        wait_done();
        cmp_stream("after_reset");
        check("after_reset_f0", rx[0], 8'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sysex_patch_dump.md
Name: sysex_patch_dump

Overview:
- Initiator and reader for the synth parameter register bus.
- On request, walks every parameter address of every register section (osc, env, mixer, ...). For each address it issues the read strobe with sysex_data_patch_send asserted, captures the byte the selected section drives onto the data bus, and emits the whole patch as a MIDI SysEx byte stream.
- Sits between the per-section parameter register files and the MIDI transmit UART.

Parameters:
- N_SECT, 4, number of register sections; one-hot select width.
- ADR_LAST, 127, last address scanned per section (scan runs 0..ADR_LAST).
- MFR_ID, 8'h7D, manufacturer byte sent after F0.
- DEV_ID, 8'h01, device byte sent after MFR_ID.

Ports:
- sCLK_XVXOSC  in  1  block clock.
- reset_reg_N  in  1  asynchronous active-low reset.
- dump_start  in  1  single-cycle request; ignored unless idle.
- dump_abort  in  1  single-cycle request; terminates the dump early.
- dump_busy  out  1  high from accepted start until DONE completes.
- dump_done  out  1  one-cycle pulse when the dump finishes or aborts.
- sect_sel  out  N_SECT  one-hot section select (drives osc_sel and peers).
- adr  out  7  parameter address.
- read  out  1  read strobe; responders latch on its rising edge.
- sysex_data_patch_send  out  1  enables the responder's tristate driver.
- data_in  in  8  resolved data bus value; the top level connects it to the shared inout.
- tx_byte  out  8  byte to the MIDI transmitter.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  transmitter accepts; a transfer occurs when tx_valid and tx_ready are both high on a clock edge.

Behaviour:
Reset values:
- Reset is asynchronous, active-low, on reset_reg_N; the block is clocked by sCLK_XVXOSC.
- On reset all outputs are 0, the state is IDLE, and sect, adr and checksum are cleared.
- Reset mid-dump discards everything. No partial F7 is sent.

States:
- IDLE: dump_start moves to H0; dump_busy rises the next cycle.
- H0, H1, H2, H3 (header): emit F0, MFR_ID, DEV_ID, then the section index (0..N_SECT-1) for the current section.
- SETUP (1 cycle): adr and sect_sel are valid; sysex_data_patch_send=1.
- RD (1 cycle): read=1.
- WAIT (1 cycle): read=0.
- CAP: register data_in.
- SHI: emit {4'h0, byte[7:4]}.
- SLO: emit {4'h0, byte[3:0]}.
- NEXT (address advance):
  - if adr<ADR_LAST: adr+1, go to SETUP;
  - else if more sections remain: sect+1, adr=0, go to H3;
  - else go to CK.
- CK: emit the checksum.
- EOX: emit F7.
- DONE: 1 cycle; dump_done=1, dump_busy=0 the following cycle, return to IDLE.

Timing and signal rules:
- Minimum per-address cost with tx_ready held high is 6 cycles: SETUP, RD, WAIT, CAP, SHI, SLO.
- sysex_data_patch_send and sect_sel stay asserted from SETUP through CAP, and are 0 in all other states.
- adr holds stable from SETUP through CAP.

Transmit handshake:
- Every emit state holds tx_valid=1 and tx_byte constant until the transfer completes. The FSM advances only on that edge.
- tx_valid is never deasserted before acceptance.
- tx_valid=0 in all non-emit states.

Checksum:
- 7-bit running sum of every nibble byte (SHI/SLO) only, excluding the header.
- Cleared on start.
- Byte sent = (0 - sum) & 7F, so that sum + checksum ≡ 0 mod 128.

Abort:
- dump_abort in any non-IDLE state jumps to EOX. If an emit is pending, that byte completes its handshake first.
- Then F7 is sent, then DONE.
- Abort in IDLE is ignored. Simultaneous start and abort in IDLE: start wins and the abort is ignored.

Boundary conditions:
- dump_start while busy is ignored.
- The adr counter never exceeds ADR_LAST and does not wrap.
- Every emitted byte except F0/F7 is below 8'h80.

Test Plan:
1. Single-address format: N_SECT=1, ADR_LAST=0, responder returns 8'hA5 when adr=0; tx_ready tied 1.
   - Stream: F0 7D 01 00 0A 05 71 F7.
   - One dump_done pulse; dump_busy low afterwards.
2. Read sequencing: responder at adr 6 and 22 with osc_sel returns 8'hF3 and 8'h10.
   - Bytes for those addresses are 0F 03 and 01 00.
   - read pulses exactly once per address, one cycle wide, with patch_send and adr stable around it.
3. Multi-section: N_SECT=2, ADR_LAST=1, all data 0.
   - Stream: F0 7D 01 00 00 00 00 00 01 00 00 00 00 00 F7.
   - sect_sel walks 01 then 10.
4. Back-pressure: random tx_ready stalls of 0–5 cycles.
   - Byte sequence is identical to the unstalled run.
   - tx_byte is stable while tx_valid=1 and tx_ready=0.
5. Abort: assert dump_abort during the 3rd address's SHI while tx_ready=0, then release tx_ready.
   - The SHI byte completes, then F7, then dump_done.
   - No further read pulses.
6. Reset mid-dump: drop reset_reg_N during WAIT.
   - All outputs are 0 immediately.
   - A new dump_start after release produces a complete stream beginning with F0.
